alu_acc_ctrl: RTL and testbench

Accumulator-based command sequencer that owns an `alu16` instance and issues operations to it in hardware. Commands arrive over a valid/ready channel, execute against a 16-bit accumulator, optionally repeat N times, and return the result and flags over a valid/ready response channel. It sits between a host or register interface and the combinational ALU datapath, replacing stimulus-driven operation with a clocked initiator.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_acc_ctrl_if.sv | 29 ++
 rtl/alu16.sv | 55 +++++
 rtl/alu_acc_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_acc_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and its alu16 datapath:
// default widths, opcode encodings, FSM states and opcode classification helpers.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL1 = 4'h6;
  localparam logic [3:0] OP_SHR1 = 4'h7;
  localparam logic [3:0] OP_EQ   = 4'h8;
  localparam logic [3:0] OP_GT   = 4'h9;
  localparam logic [3:0] OP_READ = 4'hE;
  localparam logic [3:0] OP_LOAD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_GT) || (op == OP_READ) || (op == OP_LOAD);
  endfunction

  // Opcodes 0000-0111 write the accumulator and honour the repeat count.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// Command/response channel of the accumulator sequencer.
// master = host side, slave = alu_acc_ctrl.
interface alu_acc_ctrl_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEFAULT,
  parameter int CNT_W = alu_pkg::CNT_W_DEFAULT
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [CNT_W-1:0] cmd_rpt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_neg;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, cmd_rpt, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_neg, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, cmd_rpt, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_neg, rsp_err
  );
endinterface

// File: rtl/alu16.sv
// Combinational ALU: result plus zero/carry/negative flags for the selected opcode.
// Carry is carry-out for ADD, borrow for SUB, and the shifted-out bit for shifts.
module alu16
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             neg_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    y_o     = '0;
    carry_o = 1'b0;
    sum     = '0;
    case (sel_i)
      OP_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_SUB: begin
        sum     = {1'b0, a_i} - {1'b0, b_i};
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOT:  y_o = ~a_i;
      OP_SHL1: begin
        y_o     = {a_i[WIDTH-2:0], 1'b0};
        carry_o = a_i[WIDTH-1];
      end
      OP_SHR1: begin
        y_o     = {1'b0, a_i[WIDTH-1:1]};
        carry_o = a_i[0];
      end
      OP_EQ:   y_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_GT:   y_o = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);
  assign neg_o  = y_o[WIDTH-1];

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator command sequencer driving one alu16. Build option ALU_ACC_STICKY_CARRY_EN
// makes the EXEC carry the OR over all repeat iterations instead of the last one.
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  alu_acc_ctrl_if.slave bus
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ex_zero_q;
  logic             ex_carry_q;
  logic             ex_neg_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_carry_q;
  logic             rsp_neg_q;
  logic             rsp_err_q;

  logic [WIDTH-1:0] alu_y;
  logic             alu_z;
  logic             alu_c;
  logic             alu_n;
  logic             carry_d;
  logic [CNT_W-1:0] cnt_d;

  alu16 #(.WIDTH(WIDTH)) u_alu (
    .a_i     (acc_q),
    .b_i     (opnd_q),
    .sel_i   (op_q),
    .y_o     (alu_y),
    .zero_o  (alu_z),
    .carry_o (alu_c),
    .neg_o   (alu_n)
  );

`ifdef ALU_ACC_STICKY_CARRY_EN
  assign carry_d = ex_carry_q | alu_c;
`else
  assign carry_d = alu_c;
`endif

  assign cnt_d = (bus.cmd_rpt == '0) ? CNT_W'(1) : bus.cmd_rpt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      ex_zero_q   <= 1'b0;
      ex_carry_q  <= 1'b0;
      ex_neg_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            opnd_q      <= bus.cmd_operand;
            cnt_q       <= cnt_d;
            ex_carry_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            state_q     <= is_exec_op(bus.cmd_op) ? ST_EXEC : ST_RESP;
          end
        end
        ST_EXEC: begin
          acc_q      <= alu_y;
          ex_zero_q  <= alu_z;
          ex_neg_q   <= alu_n;
          ex_carry_q <= carry_d;
          cnt_q      <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          // First RESP cycle builds the response; afterwards it is frozen until taken.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_carry_q <= 1'b0;
            if (is_exec_op(op_q)) begin
              rsp_data_q  <= acc_q;
              rsp_zero_q  <= ex_zero_q;
              rsp_carry_q <= ex_carry_q;
              rsp_neg_q   <= ex_neg_q;
            end else if (!is_legal_op(op_q)) begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= acc_q;
              rsp_zero_q <= 1'b0;
              rsp_neg_q  <= 1'b0;
            end else if (op_q == OP_LOAD) begin
              acc_q      <= opnd_q;
              rsp_data_q <= opnd_q;
              rsp_zero_q <= (opnd_q == '0);
              rsp_neg_q  <= opnd_q[WIDTH-1];
            end else if (op_q == OP_READ) begin
              rsp_data_q <= acc_q;
              rsp_zero_q <= (acc_q == '0);
              rsp_neg_q  <= acc_q[WIDTH-1];
            end else begin
              rsp_data_q  <= alu_y;
              rsp_zero_q  <= alu_z;
              rsp_carry_q <= alu_c;
              rsp_neg_q   <= alu_n;
            end
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_neg   = rsp_neg_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Scoreboard bench for alu_acc_ctrl: directed scenarios plus random commands checked
// against an arithmetic accumulator model. Honours ALU_ACC_STICKY_CARRY_EN like the RTL.
module tb_alu_acc_ctrl;

  localparam int W  = 16;
  localparam int CW = 4;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic        c;
    logic        n;
    logic        e;
    int          t;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_acc_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_acc_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   macc    = 0;
  int   bp_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Reference model: applies the command to macc using plain integer arithmetic.
  task automatic model(input int op, input int b, input int rpt, output exp_t e);
    int r, c, cs, n;
    e  = '{default: 0};
    n  = (rpt == 0) ? 1 : rpt;
    r  = 0;
    c  = 0;
    cs = 0;
    if (op <= 7) begin
      for (int i = 0; i < n; i++) begin
        c = 0;
        case (op)
          0: begin r = macc + b; c = (r > 65535) ? 1 : 0; r = r % 65536; end
          1: begin c = (macc < b) ? 1 : 0; r = (macc - b + 65536) % 65536; end
          2: r = macc & b;
          3: r = macc | b;
          4: r = macc ^ b;
          5: r = 65535 - macc;
          6: begin c = macc / 32768; r = (macc * 2) % 65536; end
          default: begin c = macc % 2; r = macc / 2; end
        endcase
        macc = r;
        cs   = cs | c;
      end
`ifdef ALU_ACC_STICKY_CARRY_EN
      e.c = cs[0];
`else
      e.c = c[0];
`endif
      e.d   = macc[15:0];
      e.z   = (macc == 0);
      e.n   = (macc >= 32768);
      e.lat = n + 1;
    end else begin
      e.lat = 1;
      if (op == 8 || op == 9) begin
        r   = (op == 8) ? ((macc == b) ? 1 : 0) : ((macc > b) ? 1 : 0);
        e.d = r[15:0];
        e.z = (r == 0);
      end else if (op == 14) begin
        e.d = macc[15:0];
        e.z = (macc == 0);
        e.n = (macc >= 32768);
      end else if (op == 15) begin
        macc = b;
        e.d  = b[15:0];
        e.z  = (b == 0);
        e.n  = (b >= 32768);
      end else begin
        e.e = 1'b1;
        e.d = macc[15:0];
      end
    end
  endtask

  task automatic send(input int op, input int b, input int rpt);
    exp_t e;
    int   wt;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op[3:0];
    bus.cmd_operand = b[15:0];
    bus.cmd_rpt     = rpt[3:0];
    wt = 0;
    while (!bus.cmd_ready && wt < 300) begin
      @(negedge clk);
      wt++;
    end
    if (!bus.cmd_ready) begin
      bound_fail("cmd_accept");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(op, b, rpt, e);
    e.t = cyc;
    sb.push_back(e);
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'($urandom);
    bus.cmd_operand = 16'($urandom);
    bus.cmd_rpt     = 4'($urandom);
  endtask

  task automatic drain();
    int wt;
    wt = 0;
    while (sb.size() != 0 && wt < 500) begin
      @(negedge clk);
      wt++;
    end
    if (sb.size() != 0) bound_fail("drain");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks every cycle a response is presented, pops on handshake.
  bit   seen = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      chk("cmd_ready_while_rsp", bus.cmd_ready, 1'b0);
      if (!seen) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_rsp");
        end else begin
          cur  = sb[0];
          seen = 1'b1;
          chk("rsp_latency", cyc - cur.t, cur.lat);
        end
      end
      if (seen) begin
        chk("rsp_data",  bus.rsp_data,  cur.d);
        chk("rsp_zero",  bus.rsp_zero,  cur.z);
        chk("rsp_carry", bus.rsp_carry, cur.c);
        chk("rsp_neg",   bus.rsp_neg,   cur.n);
        chk("rsp_err",   bus.rsp_err,   cur.e);
        if (bus.rsp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int op, b, rpt, r;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_operand = 16'h0;
    bus.cmd_rpt     = 4'h0;
    bus.rsp_ready   = 1'b1;
    rst = 1'b1;
    #12;
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_data",  bus.rsp_data,  16'h0);
    chk("reset_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_neg, bus.rsp_err}, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    send(15, 16'h000A, 0);
    send(0,  16'h0005, 0);
    send(15, 16'h000A, 0);
    send(6,  16'h0000, 4);
    send(15, 16'h0001, 0);
    send(0,  16'hFFFF, 1);
    send(15, 16'h8000, 0);
    send(6,  16'h0000, 2);
    send(15, 16'h000A, 0);
    send(9,  16'h0005, 0);
    send(14, 16'h0000, 0);
    send(8,  16'h000A, 0);
    send(1,  16'h000B, 1);
    drain();

    // Illegal opcode held under backpressure.
    bp_mode = 1;
    send(11, 16'h1234, 0);
    repeat (5) @(negedge clk);
    bp_mode = 2;
    drain();

    // Reset in the middle of a long EXEC.
    send(15, 16'h1234, 0);
    send(0,  16'h0001, 8);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_mid_rsp_data",  bus.rsp_data,  16'h0);
    sb.delete();
    seen = 1'b0;
    macc = 0;
    @(negedge clk);
    rst = 1'b0;
    send(14, 16'h0000, 0);
    drain();

    bp_mode = 0;
    for (int k = 0; k < 60; k++) begin
      r   = $urandom_range(0, 19);
      op  = (r >= 16) ? 15 : r;
      b   = $urandom_range(0, 65535);
      rpt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      send(op, b, rpt);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
